xc_aessub_seq: RTL and testbench

- Multi-cycle sequencer for the XCrypto AES SubBytes instruction family: xc.aessub.enc, .encrot, .dec and .decrot.
- Sits in the core's execute stage beside the other crypto functional units.
- Time-multiplexes a small number of shared S-box lanes across the four result bytes, instead of using four full S-boxes.
- Its result must match the combinational xc_aessub_checker golden model for every rs1, rs2, enc and rot value.

---
 rtl/xc_aes_pkg.sv | 44 ++++
 rtl/xc_aes_sbox.sv | 14 +
 rtl/xc_aessub_seq.sv | 115 +++++++++++
 tb/tb_xc_aessub_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_aes_pkg.sv
// Shared definitions for the AES SubBytes sequencer: S-box tables, FSM
// encoding and the byte-gather mask.
// Latency: n/a (constants only).  Backpressure: n/a.
package xc_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte i of the gathered word comes from rs2 where the mask byte is set,
  // otherwise from rs1: {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]}.
  localparam logic [31:0] GATHER_RS2_MASK = 32'hFF00_FF00;

  function automatic logic [31:0] gather_bytes(input logic [31:0] src1,
                                               input logic [31:0] src2);
    return (src1 & ~GATHER_RS2_MASK) | (src2 & GATHER_RS2_MASK);
  endfunction

  // Ascending outer range so that element x is entry x of the table.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/xc_aes_sbox.sv
// One AES S-box lane: forward (enc=1) or inverse (enc=0) byte substitution.
// Latency: combinational.  Backpressure: none.
// Ports: enc selects direction, din is the byte in, dout the substituted byte.
module xc_aes_sbox
  import xc_aes_pkg::*;
(
  input  logic       enc,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = enc ? SBOX_FWD[din] : SBOX_INV[din];

endmodule

// File: rtl/xc_aessub_seq.sv
// Multi-cycle xc.aessub sequencer sharing SBOX_LANES S-box lanes over four bytes.
// Latency: accept at cycle t -> ready pulse at t + 4/SBOX_LANES + 1.
// Backpressure: valid must stay high until ready; dropping it while busy aborts.
// Ports: g_clk/g_resetn clock and async active-low reset; valid, rs1, rs2,
//   enc, rot request; ready one-cycle result strobe, result data, busy.
module xc_aessub_seq
  import xc_aes_pkg::*;
#(
  parameter int SBOX_LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] result,
  output logic        busy
);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("xc_aessub_seq: SBOX_LANES must be 1, 2 or 4");
  end

  // With 4 lanes the step wraps the 2-bit counter to 0, which is harmless
  // because the operation always finishes in a single BUSY cycle.
  localparam logic [1:0] CNT_STEP = 2'(SBOX_LANES);
  localparam logic [1:0] CNT_LAST = 2'(4 - SBOX_LANES);

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] op_q;    // gathered bytes t3..t0
  logic        enc_q;
  logic        rot_q;
  logic [31:0] acc_q;   // S(t3)..S(t0), unrotated

  logic [SBOX_LANES-1:0][1:0] lane_idx;
  logic [SBOX_LANES-1:0][7:0] lane_out;
  logic [31:0]                acc_nxt;
  logic [31:0]                res_nxt;

  // Lane k is hard-wired to byte cnt+k, so lanes never alias.
  for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
    assign lane_idx[k] = cnt + 2'(k);
    xc_aes_sbox u_sbox (
      .enc  (enc_q),
      .din  (op_q[{lane_idx[k], 3'b000} +: 8]),
      .dout (lane_out[k])
    );
  end

  always_comb begin
    acc_nxt = acc_q;
    for (int k = 0; k < SBOX_LANES; k++) begin
      acc_nxt[{lane_idx[k], 3'b000} +: 8] = lane_out[k];
    end
  end

  // The final BUSY cycle registers the result straight from acc_nxt so the
  // last lookups do not need an extra cycle to reach the output.
  assign res_nxt = rot_q ? {acc_nxt[23:0], acc_nxt[31:24]} : acc_nxt;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      op_q   <= 32'd0;
      enc_q  <= 1'b0;
      rot_q  <= 1'b0;
      acc_q  <= 32'd0;
      ready  <= 1'b0;
      busy   <= 1'b0;
      result <= 32'd0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            op_q  <= gather_bytes(rs1, rs2);
            enc_q <= enc;
            rot_q <= rot;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!valid) begin
            // Abort: result keeps its previous value, no ready.
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc_q <= acc_nxt;
            cnt   <= cnt + CNT_STEP;
            if (cnt == CNT_LAST) begin
              result <= res_nxt;
              ready  <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Bench for xc_aessub_seq: three instances (1, 2, 4 lanes) against a
// cycle-count reference model built on S-boxes derived from GF(2^8) arithmetic.
module tb_xc_aessub_seq;

  logic              g_clk = 1'b0;
  logic              g_resetn;
  logic [2:0]        valid, enc, rot, ready, busy;
  logic [2:0][31:0]  rs1, rs2, result;

  always #5 g_clk = ~g_clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int L = (i == 0) ? 1 : (i == 1) ? 2 : 4;
    xc_aessub_seq #(.SBOX_LANES(L)) u_dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .valid    (valid[i]),
      .rs1      (rs1[i]),
      .rs2      (rs2[i]),
      .enc      (enc[i]),
      .rot      (rot[i]),
      .ready    (ready[i]),
      .result   (result[i]),
      .busy     (busy[i])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int lanes(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // ---------------- reference S-boxes from first principles ----------------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'd0;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'd1) b = 8'(y);
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic e, input logic r);
    logic [7:0]  t [4];
    logic [31:0] o;
    t[0] = a[7:0];  t[1] = b[15:8];  t[2] = a[23:16];  t[3] = b[31:24];
    for (int i = 0; i < 4; i++) o[i*8 +: 8] = e ? fwd_t[t[i]] : inv_t[t[i]];
    return r ? {o[23:0], o[31:24]} : o;
  endfunction

  // ---------------- cycle-level reference model ----------------
  int          cyc = 0;
  int          m_start [3];
  bit          m_active [3], m_done [3], e_ready [3], e_busy [3];
  logic [31:0] m_val [3], e_result [3];

  initial for (int d = 0; d < 3; d++) begin
    m_start[d] = 0; m_active[d] = 0; m_done[d] = 0;
    e_ready[d] = 0; e_busy[d] = 0; m_val[d] = 0; e_result[d] = 0;
  end

  always @(posedge g_clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (!g_resetn) begin
        m_active[d] <= 0; m_done[d] <= 0;
        e_ready[d] <= 0; e_busy[d] <= 0; e_result[d] <= 32'd0;
      end else if (m_done[d]) begin
        m_done[d]  <= 0;
        e_ready[d] <= 0;
      end else if (m_active[d]) begin
        if (!valid[d]) begin
          m_active[d] <= 0;
          e_busy[d]   <= 0;
        end else if (cyc == m_start[d] + 4 / lanes(d)) begin
          m_active[d] <= 0;
          m_done[d]   <= 1;
          e_busy[d]   <= 0;
          e_ready[d]  <= 1;
          e_result[d] <= m_val[d];
        end
      end else if (valid[d]) begin
        m_active[d] <= 1;
        m_start[d]  <= cyc;
        m_val[d]    <= golden(rs1[d], rs2[d], enc[d], rot[d]);
        e_busy[d]   <= 1;
      end
    end
  end

  always @(negedge g_clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!g_resetn) begin
        chk($sformatf("d%0d_rst_ready", d), 32'(ready[d]), 32'd0);
        chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
        chk($sformatf("d%0d_rst_result", d), result[d], 32'd0);
      end else begin
        chk($sformatf("d%0d_ready", d), 32'(ready[d]), 32'(e_ready[d]));
        chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(e_busy[d]));
        chk($sformatf("d%0d_result", d), result[d], e_result[d]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic e, input logic r, input bit scramble,
                     output logic [31:0] res, output int lat, output int bcnt);
    @(negedge g_clk);
    rs1[d] = a; rs2[d] = b; enc[d] = e; rot[d] = r; valid[d] = 1'b1;
    lat = 0; bcnt = 0; res = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge g_clk);
      lat++;
      if (ready[d]) break;
      if (busy[d]) bcnt++;
      if (scramble) begin
        rs1[d] = $urandom; rs2[d] = $urandom;
        enc[d] = 1'($urandom_range(0, 1)); rot[d] = 1'($urandom_range(0, 1));
      end
    end
    if (!ready[d]) begin
      n_chk++; n_fail++;
      $display("FAIL d%0d_ready_timeout: got no ready within %0d cycles expected ready", d, lat);
    end
    res = result[d];
    valid[d] = 1'b0;
  endtask

  logic [31:0] res, a, b;
  int          lat, bcnt, nrdy;
  logic        e, r;

  initial begin
    valid = '0; enc = '0; rot = '0; rs1 = '0; rs2 = '0;
    g_resetn = 1'b1;
    build_tables();
    // Pin the reference model with known AES values.
    chk("pin_fwd_00", 32'(fwd_t[8'h00]), 32'h63);
    chk("pin_fwd_53", 32'(fwd_t[8'h53]), 32'hed);
    chk("pin_fwd_ff", 32'(fwd_t[8'hff]), 32'h16);
    chk("pin_inv_7c", 32'(inv_t[8'h7c]), 32'h01);
    chk("pin_golden_enc", golden(32'h00530001, 32'hFF000000, 1'b1, 1'b0), 32'h16ED637C);

    #1 g_resetn = 1'b0;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(ready[d]), 32'd0);
      chk("reset_result", result[d], 32'd0);
    end
    @(posedge g_clk); #2 g_resetn = 1'b1;

    // Directed: encrypt, encrypt+rotate, decrypt on all lane counts.
    run(0, 32'h00530001, 32'hFF000000, 1'b1, 1'b0, 1'b0, res, lat, bcnt);
    chk("enc_result", res, 32'h16ED637C);
    chk("enc_latency", 32'(lat), 32'd5);
    chk("enc_busy_cycles", 32'(bcnt), 32'd4);
    run(0, 32'h00530001, 32'hFF000000, 1'b1, 1'b1, 1'b0, res, lat, bcnt);
    chk("encrot_result", res, 32'hED637C16);
    run(2, 32'h00ED007C, 32'h16006300, 1'b0, 1'b0, 1'b0, res, lat, bcnt);
    chk("dec4_result", res, 32'hFF530001);
    chk("dec4_latency", 32'(lat), 32'd2);
    run(1, 32'h00ED007C, 32'h16006300, 1'b0, 1'b0, 1'b0, res, lat, bcnt);
    chk("dec2_result", res, 32'hFF530001);
    chk("dec2_latency", 32'(lat), 32'd3);
    run(0, 32'h00ED007C, 32'h16006300, 1'b0, 1'b0, 1'b0, res, lat, bcnt);
    chk("dec1_result", res, 32'hFF530001);

    // Abort: drop valid at t+2, re-present with zero operands at t+4.
    @(negedge g_clk);
    rs1[0] = 32'h00530001; rs2[0] = 32'hFF000000; enc[0] = 1'b1; rot[0] = 1'b0;
    valid[0] = 1'b1;
    @(negedge g_clk);
    @(negedge g_clk);
    chk("abort_busy_before", 32'(busy[0]), 32'd1);
    valid[0] = 1'b0;
    @(negedge g_clk);
    chk("abort_busy_after", 32'(busy[0]), 32'd0);
    chk("abort_result_kept", result[0], 32'hFF530001);
    run(0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, res, lat, bcnt);
    chk("after_abort_result", res, 32'h63636363);
    chk("after_abort_latency", 32'(lat), 32'd5);

    // Reset in the middle of an operation.
    @(negedge g_clk);
    rs1[0] = 32'h00530001; rs2[0] = 32'hFF000000; enc[0] = 1'b1; valid[0] = 1'b1;
    repeat (3) @(posedge g_clk);
    #2 g_resetn = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_result", result[0], 32'd0);
    valid[0] = 1'b0;
    repeat (2) @(posedge g_clk);
    #2 g_resetn = 1'b1;
    nrdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge g_clk);
      if (ready[0]) nrdy++;
    end
    chk("no_stale_ready", 32'(nrdy), 32'd0);

    // Random equivalence, sometimes wiggling operands while busy.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge g_clk);
        a = $urandom; b = $urandom;
        e = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
        run(d, a, b, e, r, ($urandom_range(0, 3) == 0), res, lat, bcnt);
        chk($sformatf("rand_d%0d_result", d), res, golden(a, b, e, r));
        chk($sformatf("rand_d%0d_latency", d), 32'(lat), 32'(4 / lanes(d) + 1));
      end
    end

    repeat (3) @(negedge g_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
